// File: rtl/riscv_mmio_pkg.sv
// Shared MMIO definitions for the RISC-V multi-cycle core's peripherals.
// Holds the GPIO base address used by the core's address decoder and the
// word offsets of the GPIO register file.
package riscv_mmio_pkg;

  localparam logic [31:0] GPIO_BASE = 32'h1000_0000;

  typedef enum logic [1:0] {
    GPIO_IN    = 2'd0,
    GPIO_OUT   = 2'd1,
    GPIO_EDGE  = 2'd2,
    GPIO_IRQEN = 2'd3
  } gpio_reg_e;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO input bit: 2-FF synchronizer, consecutive-cycle debouncer and
// rising-edge detect. 'rise' is combinational and marks the cycle in which
// 'stable' is about to go 0->1, so the parent can flag the edge on the same
// clock edge that updates 'stable'.
module gpio_debounce_bit #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  // Stable value flips when the synced bit has differed for DEB_CYCLES cycles.
  always_comb begin
    flip = (s2 != stable) && (cnt == CNT_LAST);
    rise = flip & s2;
  end

  // Synchronizer, debounce counter and stable value.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse s1/s2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_port_ctrl.sv
// Memory-mapped GPIO peripheral: conditioned inputs (IN), output latch (OUT),
// sticky write-1-to-clear rising-edge flags (EDGE), interrupt enables
// (IRQ_EN) and a registered level interrupt. Single-cycle bus, no stalls.
module gpio_port_ctrl
  import riscv_mmio_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_sel,
  input  logic             bus_we,
  input  logic [1:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic             irq
);

  logic [WIDTH-1:0] in_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] irq_en_q;
  logic [WIDTH-1:0] edge_next;
  logic [WIDTH-1:0] irq_en_next;
  logic [WIDTH-1:0] clr;
  logic             wr;
  gpio_reg_e        reg_sel;
  logic             unused_wdata;

  assign wr           = bus_sel & bus_we;
  assign reg_sel      = gpio_reg_e'(bus_addr);
  assign gpio_out     = out_q;
  assign unused_wdata = ^bus_wdata[31:WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .pin    (gpio_in[i]),
      .stable (in_q[i]),
      .rise   (rise[i])
    );
  end

  // Next-state of EDGE and IRQ_EN; irq is registered from these so it tracks
  // them on the same edge rather than lagging one more cycle.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    clr         = '0;
    irq_en_next = irq_en_q;
    if (wr && reg_sel == GPIO_EDGE)  clr         = bus_wdata[WIDTH-1:0];
    if (wr && reg_sel == GPIO_IRQEN) irq_en_next = bus_wdata[WIDTH-1:0];
    // A new rise beats a simultaneous clear of the same bit.
    edge_next = (edge_q & ~clr) | rise;
  end

  // Register file and interrupt output.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      edge_q   <= '0;
      irq_en_q <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr && reg_sel == GPIO_OUT) out_q <= bus_wdata[WIDTH-1:0];
      edge_q   <= edge_next;
      irq_en_q <= irq_en_next;
      irq      <= |(edge_next & irq_en_next);
    end
  end

  // Read mux: zero-extended register contents, no side effects.
  always_comb begin
    bus_rdata = '0;
    if (bus_sel) begin
      case (reg_sel)
        GPIO_IN:    bus_rdata = 32'(in_q);
        GPIO_OUT:   bus_rdata = 32'(out_q);
        GPIO_EDGE:  bus_rdata = 32'(edge_q);
        GPIO_IRQEN: bus_rdata = 32'(irq_en_q);
        default:    bus_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Self-checking bench for gpio_port_ctrl: a table of single-cycle bus
// vectors for the register file, then hand-written sequences for reset,
// debounce latency, glitch rejection, interrupts and the clear/set race.
module tb_gpio_port_ctrl;
  import riscv_mmio_pkg::*;

  localparam int WIDTH = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             bus_sel;
  logic             bus_we;
  logic [1:0]       bus_addr;
  logic [31:0]      bus_wdata;
  logic [31:0]      bus_rdata;
  logic [WIDTH-1:0] gpio_in;
  logic [WIDTH-1:0] gpio_out;
  logic             irq;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic             sel;
    logic             we;
    logic [1:0]       addr;
    logic [31:0]      wdata;
    logic [31:0]      exp_rdata;
    logic [WIDTH-1:0] exp_out;
    logic             exp_irq;
  } vec_t;

  vec_t vecs[15];

  gpio_port_ctrl #(.WIDTH(WIDTH), .DEB_CYCLES(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_sel   (bus_sel),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  task automatic idle_bus();
    bus_sel   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 2'd0;
    bus_wdata = 32'h0;
  endtask

  // Two reset posedges; returns at a negedge with rst just released.
  task automatic do_reset(input logic [WIDTH-1:0] pins);
    @(negedge clk);
    rst     = 1'b1;
    gpio_in = pins;
    idle_bus();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Combinational read at the current (negedge) point, no cycle consumed.
  task automatic read_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus_sel = 1'b1;
    bus_we  = 1'b0;
    bus_addr = a;
    #1;
    check(name, bus_rdata, exp);
  endtask

  // One-cycle write; returns at the negedge after it has taken effect.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_sel   = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = a;
    bus_wdata = d;
    @(negedge clk);
    idle_bus();
  endtask

  initial begin
    // sel we addr wdata  exp_rdata  exp_out  exp_irq
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h0,         32'h0,   10'h000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'd1, 32'h0,         32'h0,   10'h000, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h0,   10'h000, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'd3, 32'h0,         32'h0,   10'h000, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 2'd1, 32'h155,       32'h0,   10'h000, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'd1, 32'h0,         32'h155, 10'h155, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 2'd0, 32'h3FF,       32'h0,   10'h155, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 32'h0,         32'h0,   10'h155, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0,   10'h155, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 2'd3, 32'h0,         32'h3FF, 10'h155, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 2'd1, 32'h0,         32'h0,   10'h155, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 2'd1, 32'h0,         32'h0,   10'h155, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 2'd1, 32'h0,         32'h155, 10'h155, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 2'd3, 32'h0,         32'h3FF, 10'h155, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 2'd3, 32'h0,         32'h0,   10'h155, 1'b0};

    // Reset held two cycles with all pins high: everything reads zero.
    rst     = 1'b1;
    gpio_in = 10'h3FF;
    idle_bus();
    repeat (2) @(negedge clk);
    read_chk(GPIO_IN,    32'h0, "rst_in");
    read_chk(GPIO_OUT,   32'h0, "rst_out_reg");
    read_chk(GPIO_EDGE,  32'h0, "rst_edge");
    read_chk(GPIO_IRQEN, 32'h0, "rst_irqen");
    check("rst_gpio_out", 32'(gpio_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    idle_bus();
    gpio_in = '0;
    @(negedge clk);
    rst = 1'b0;

    // Register-file vectors.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus_sel   = vecs[i].sel;
      bus_we    = vecs[i].we;
      bus_addr  = vecs[i].addr;
      bus_wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_rdata", i), bus_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_out", i), 32'(gpio_out), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
    end

    // Reset clears a non-zero OUT.
    do_reset('0);
    check("rst_clears_out", 32'(gpio_out), 32'h0);

    // Debounce pass: IN follows exactly 6 posedges after the pin changes.
    gpio_in = 10'd2;
    repeat (5) @(negedge clk);
    read_chk(GPIO_IN,   32'h0, "deb_in_early");
    read_chk(GPIO_EDGE, 32'h0, "deb_edge_early");
    @(negedge clk);
    read_chk(GPIO_IN,   32'h2, "deb_in_on_time");
    read_chk(GPIO_EDGE, 32'h2, "deb_edge_on_time");

    // Glitch of 3 cycles is rejected; a 4-cycle pulse is just long enough.
    do_reset('0);
    gpio_in = 10'h001;
    repeat (3) @(negedge clk);
    gpio_in = '0;
    repeat (10) @(negedge clk);
    read_chk(GPIO_IN,   32'h0, "glitch3_in");
    read_chk(GPIO_EDGE, 32'h0, "glitch3_edge");
    gpio_in = 10'h004;
    repeat (4) @(negedge clk);
    gpio_in = '0;
    repeat (10) @(negedge clk);
    read_chk(GPIO_IN,   32'h0, "pulse4_in_back");
    read_chk(GPIO_EDGE, 32'h4, "pulse4_edge");

    // IRQ follows enabled EDGE on the same edge; W1C drops it next cycle.
    do_reset('0);
    bus_write(GPIO_IRQEN, 32'h2);
    gpio_in = 10'd2;
    check("irq_idle", 32'(irq), 32'h0);
    repeat (5) @(negedge clk);
    check("irq_before_edge", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'h1);
    read_chk(GPIO_EDGE, 32'h2, "irq_edge_set");
    bus_write(GPIO_EDGE, 32'h2);
    check("irq_cleared", 32'(irq), 32'h0);
    read_chk(GPIO_EDGE, 32'h0, "irq_edge_cleared");
    // Edge on a disabled bit is flagged but raises no interrupt.
    gpio_in = 10'h012;
    repeat (8) @(negedge clk);
    read_chk(GPIO_EDGE, 32'h10, "irq_masked_edge");
    check("irq_masked", 32'(irq), 32'h0);

    // Clear and rise of the same bit in one cycle: the set wins.
    do_reset('0);
    gpio_in = 10'd2;
    repeat (5) @(negedge clk);
    bus_sel   = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = GPIO_EDGE;
    bus_wdata = 32'h2;
    @(negedge clk);
    idle_bus();
    read_chk(GPIO_EDGE, 32'h2, "race_set_wins");
    bus_write(GPIO_EDGE, 32'h2);
    read_chk(GPIO_EDGE, 32'h0, "race_later_clear");

    // Reset in the middle of a debounce count: no edge, no input change.
    do_reset('0);
    gpio_in = 10'h008;
    repeat (4) @(negedge clk);
    rst     = 1'b1;
    gpio_in = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    read_chk(GPIO_IN,   32'h0, "midrst_in");
    read_chk(GPIO_EDGE, 32'h0, "midrst_edge");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
